// File: rtl/apb4_ps2_core.sv
// APB4 slave PS/2 device-to-host receiver: pin synchronisers, 11-bit frame deframer,
// byte RX FIFO and a level interrupt for pending data or frame/overflow errors.
module apb4_ps2_core #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] paddr,
  input  logic [2:0]  pprot,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

  state_t      state, state_next;
  logic [7:0]  shift, shift_next;
  logic [2:0]  bit_cnt, bit_cnt_next;
  logic        par_bit, par_bit_next;
  logic        push, frame_err;

  logic        clk_s1, clk_s2, clk_s3;
  logic        dat_s1, dat_s2;
  logic        fall;

  logic        en, inten, perr, ovf, irq;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        full, nempty, pop, push_ok, ovf_set;
  logic        wr_access, wr_ctrl, wr_stat;

  logic        unused_ok;
  assign unused_ok = ^{pprot, pstrb, paddr[31:4], paddr[1:0], pwdata[31:3]};

  assign pready  = 1'b1;
  assign pslverr = 1'b0;
  assign irq_o   = irq;

  // Lines idle high, so synchronisers reset to 1 to avoid a spurious edge.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_i;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_dat_i;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= S_IDLE;
      shift   <= 8'h00;
      bit_cnt <= 3'd0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_cnt <= bit_cnt_next;
      par_bit <= par_bit_next;
    end
  end

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    par_bit_next = par_bit;
    push         = 1'b0;
    frame_err    = 1'b0;
    if (!en) begin
      state_next = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE: begin
          if (!dat_s2) begin
            state_next   = S_DATA;
            shift_next   = 8'h00;
            bit_cnt_next = 3'd0;
            par_bit_next = 1'b0;
          end
        end
        S_DATA: begin
          shift_next   = {dat_s2, shift[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = S_PAR;
        end
        S_PAR: begin
          par_bit_next = dat_s2;
          state_next   = S_STOP;
        end
        S_STOP: begin
          state_next = S_IDLE;
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (dat_s2 && (^{shift, par_bit})) push = 1'b1;
          else                               frame_err = 1'b1;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign nempty    = (count != '0);
  assign pop       = psel & penable & ~pwrite & (paddr[3:2] == 2'd1) & nempty;
  assign push_ok   = push & (~full | pop);
  assign ovf_set   = push & full & ~pop;
  assign wr_access = psel & penable & pwrite;
  assign wr_ctrl   = wr_access & (paddr[3:2] == 2'd0);
  assign wr_stat   = wr_access & (paddr[3:2] == 2'd2);

  always_ff @(posedge pclk) begin
    if (push_ok) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Error flags: a new event in the same cycle as a clear wins.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      en    <= 1'b0;
      inten <= 1'b0;
      perr  <= 1'b0;
      ovf   <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en    <= pwdata[0];
        inten <= pwdata[1];
      end
      perr <= (perr & ~(wr_stat & pwdata[1])) | frame_err;
      ovf  <= (ovf  & ~(wr_stat & pwdata[2])) | ovf_set;
      irq  <= inten & (nempty | perr | ovf);
    end
  end

  always_comb begin
    prdata = 32'h0;
    case (paddr[3:2])
      2'd0: prdata = {30'h0, inten, en};
      2'd1: prdata = nempty ? {24'h0, mem[rd_ptr]} : 32'h0;
      2'd2: prdata = {28'h0, full, ovf, perr, nempty};
      default: prdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_apb4_ps2_core.sv
// Bench for apb4_ps2_core: bit-level PS/2 device driver, APB master tasks and a
// queue-based model of the receive path (FIFO contents, error flags, interrupt).
module tb_apb4_ps2_core;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic [31:0] paddr = '0;
  logic [2:0]  pprot = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = 4'hF;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic        irq_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_q[$];
  logic       m_en = 1'b0, m_inten = 1'b0, m_perr = 1'b0, m_ovf = 1'b0;

  apb4_ps2_core #(.FIFO_DEPTH(8)) dut (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pprot(pprot), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat), .irq_o(irq_o)
  );

  always #5 pclk = ~pclk;

  function automatic logic [31:0] exp_stat();
    return {28'h0, (m_q.size() == 8), m_ovf, m_perr, (m_q.size() != 0)};
  endfunction

  function automatic logic exp_irq();
    return m_inten & ((m_q.size() != 0) | m_perr | m_ovf);
  endfunction

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge pclk);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge pclk);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    d = prdata;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic write_ctrl(input logic en, input logic inten);
    apb_write(32'h0, {30'h0, inten, en});
    m_en = en;
    m_inten = inten;
  endtask

  task automatic write_stat(input logic [31:0] d);
    apb_write(32'h8, d);
    if (d[1]) m_perr = 1'b0;
    if (d[2]) m_ovf = 1'b0;
  endtask

  // Device drives data while its clock is high; the host samples on the falling edge.
  task automatic ps2_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = b[i];
      repeat (25) @(negedge pclk);
      ps2_clk = 1'b0;
      repeat (50) @(negedge pclk);
      ps2_clk = 1'b1;
      repeat (25) @(negedge pclk);
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic bad_stop);
    logic par;
    par = ~(^data) ^ bad_par;
    ps2_bits({~bad_stop, par, data, 1'b0}, 11);
    if (m_en) begin
      if (bad_par || bad_stop) m_perr = 1'b1;
      else if (m_q.size() == 8) m_ovf = 1'b1;
      else m_q.push_back(data);
    end
    repeat (4) @(negedge pclk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    presetn = 1'b0;
    repeat (4) @(negedge pclk);
    checks++;
    if (irq_o !== 1'b0 || pready !== 1'b1 || pslverr !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins: irq=%b pready=%b pslverr=%b, want 0 1 0", irq_o, pready, pslverr);
    end
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
    for (int a = 0; a < 3; a++) begin
      apb_read(32'(a * 4), r);
      checks++;
      if (r !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg@%0h: got %h want 0", a * 4, r);
      end
    end
  endtask

  task automatic test_good_frame();
    logic [31:0] r;
    write_ctrl(1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0);
    apb_read(32'h8, r);
    checks++;
    if (r !== exp_stat() || r !== 32'h1) begin
      errors++;
      $display("FAIL good_stat: got %h want %h", r, exp_stat());
    end
    checks++;
    if (irq_o !== 1'b1) begin
      errors++;
      $display("FAIL good_irq: got %b want 1", irq_o);
    end
    apb_read(32'h4, r);
    checks++;
    if (r !== 32'h1C) begin
      errors++;
      $display("FAIL good_data: got %h want 1c", r);
    end
    void'(m_q.pop_front());
    repeat (3) @(negedge pclk);
    apb_read(32'h8, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL good_stat_after: got %h want 0", r);
    end
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL good_irq_after: got %b want 0", irq_o);
    end
  endtask

  task automatic test_parity_error();
    logic [31:0] r;
    send_frame(8'h1C, 1'b1, 1'b0);
    apb_read(32'h8, r);
    checks++;
    if (r !== 32'h2) begin
      errors++;
      $display("FAIL perr_stat: got %h want 2", r);
    end
    checks++;
    if (irq_o !== 1'b1) begin
      errors++;
      $display("FAIL perr_irq: got %b want 1", irq_o);
    end
    write_stat(32'h2);
    apb_read(32'h8, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL perr_clear: got %h want 0", r);
    end
    send_frame(8'hA5, 1'b0, 1'b1);
    apb_read(32'h8, r);
    checks++;
    if (r !== 32'h2) begin
      errors++;
      $display("FAIL stop_err_stat: got %h want 2", r);
    end
    write_stat(32'h2);
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    logic [7:0]  e;
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    apb_read(32'h8, r);
    checks++;
    if (r !== 32'hD || r !== exp_stat()) begin
      errors++;
      $display("FAIL ovf_stat: got %h want d", r);
    end
    for (int i = 0; i < 8; i++) begin
      apb_read(32'h4, r);
      e = m_q.pop_front();
      checks++;
      if (r !== {24'h0, e} || e !== 8'(i)) begin
        errors++;
        $display("FAIL ovf_data%0d: got %h want %h", i, r, i);
      end
    end
    apb_read(32'h4, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL ovf_empty_data: got %h want 0", r);
    end
    write_stat(32'h4);
    apb_read(32'h8, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL ovf_clear: got %h want 0", r);
    end
  endtask

  task automatic test_disable_abort();
    logic [31:0] r;
    write_ctrl(1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b0);
    apb_read(32'h8, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL disabled_stat: got %h want 0", r);
    end
    write_ctrl(1'b1, 1'b1);
    ps2_bits({3'b111, 8'hB3, 1'b0}, 5);
    write_ctrl(1'b0, 1'b1);
    write_ctrl(1'b1, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0);
    apb_read(32'h8, r);
    checks++;
    if (r !== 32'h1) begin
      errors++;
      $display("FAIL abort_stat: got %h want 1", r);
    end
    apb_read(32'h4, r);
    void'(m_q.pop_front());
    checks++;
    if (r !== 32'h5A) begin
      errors++;
      $display("FAIL abort_data: got %h want 5a", r);
    end
    apb_read(32'h8, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL abort_stat_after: got %h want 0", r);
    end
  endtask

  task automatic test_unmapped_inten();
    logic [31:0] r;
    apb_write(32'hC, 32'hFFFF_FFFF);
    apb_read(32'hC, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_read: got %h want 0", r);
    end
    apb_read(32'h0, r);
    checks++;
    if (r !== 32'h3) begin
      errors++;
      $display("FAIL ctrl_readback: got %h want 3", r);
    end
    write_ctrl(1'b1, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0);
    checks++;
    if (irq_o !== 1'b0 || exp_irq() !== 1'b0) begin
      errors++;
      $display("FAIL inten_off_irq: got %b want 0", irq_o);
    end
    write_ctrl(1'b1, 1'b1);
    repeat (2) @(negedge pclk);
    checks++;
    if (irq_o !== exp_irq()) begin
      errors++;
      $display("FAIL inten_on_irq: got %b want %b", irq_o, exp_irq());
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] e;
    for (int n = 0; n < 14; n++) begin
      send_frame(8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) begin
        apb_read(32'h4, r);
        e = (m_q.size() != 0) ? {24'h0, m_q.pop_front()} : 32'h0;
        checks++;
        if (r !== e) begin
          errors++;
          $display("FAIL rand_data%0d: got %h want %h", n, r, e);
        end
      end
      apb_read(32'h8, r);
      checks++;
      if (r !== exp_stat()) begin
        errors++;
        $display("FAIL rand_stat%0d: got %h want %h", n, r, exp_stat());
      end
      repeat (2) @(negedge pclk);
      checks++;
      if (irq_o !== exp_irq()) begin
        errors++;
        $display("FAIL rand_irq%0d: got %b want %b", n, irq_o, exp_irq());
      end
      if ($urandom_range(0, 3) == 0) write_stat({29'h0, 2'($urandom), 1'b0});
    end
    while (m_q.size() != 0) begin
      apb_read(32'h4, r);
      e = {24'h0, m_q.pop_front()};
      checks++;
      if (r !== e) begin
        errors++;
        $display("FAIL rand_drain: got %h want %h", r, e);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] r;
    write_stat(32'h6);
    send_frame(8'h3C, 1'b0, 1'b0);
    ps2_bits({3'b111, 8'h81, 1'b0}, 6);
    @(negedge pclk);
    presetn = 1'b0;
    m_q.delete();
    m_en = 1'b0; m_inten = 1'b0; m_perr = 1'b0; m_ovf = 1'b0;
    #2;
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_irq: got %b want 0", irq_o);
    end
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    apb_read(32'h8, r);
    checks++;
    if (r !== exp_stat()) begin
      errors++;
      $display("FAIL midreset_stat: got %h want %h", r, exp_stat());
    end
    apb_read(32'h0, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL midreset_ctrl: got %h want 0", r);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_overflow();
    test_disable_abort();
    test_unmapped_inten();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
